// File: rtl/ai_move_engine.sv
// Two-ply minimax move search for tic-tac-toe: AI tries each empty cell, then
// every player reply is scanned one cell per cycle to find the worst outcome.
module ai_move_engine (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [17:0] board,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic [3:0]  move
);

  typedef enum logic [2:0] {S_IDLE, S_CHK, S_CAND, S_REPLY, S_FIN} state_t;

  // Each 12-bit field is one line as three hex cell indices; line 0 in the LSBs.
  localparam logic [95:0] LINES = 96'h246_048_258_147_036_678_345_012;

  localparam logic [1:0] CELL_EMPTY  = 2'b00;
  localparam logic [1:0] CELL_PLAYER = 2'b01;
  localparam logic [1:0] CELL_AI     = 2'b10;

  function automatic logic [1:0] cell_of(input logic [17:0] b, input logic [3:0] k);
    return b[2*k +: 2];
  endfunction

  function automatic logic [17:0] set_cell(input logic [17:0] b, input logic [3:0] k,
                                           input logic [1:0] v);
    logic [17:0] r;
    r = b;
    r[2*k +: 2] = v;
    return r;
  endfunction

  // 0 = open, 1 = player win, 2 = AI win, 3 = draw
  function automatic logic [1:0] eval_board(input logic [17:0] b);
    logic       p_win;
    logic       a_win;
    logic       full;
    logic [1:0] c0, c1, c2;
    p_win = 1'b0;
    a_win = 1'b0;
    full  = 1'b1;
    for (int n = 0; n < 8; n++) begin
      c0 = cell_of(b, LINES[12*n+8 +: 4]);
      c1 = cell_of(b, LINES[12*n+4 +: 4]);
      c2 = cell_of(b, LINES[12*n   +: 4]);
      if (c0 == c1 && c1 == c2) begin
        if (c0 == CELL_PLAYER) p_win = 1'b1;
        if (c0 == CELL_AI)     a_win = 1'b1;
      end
    end
    for (int k = 0; k < 9; k++) begin
      if (b[2*k +: 2] == CELL_EMPTY) full = 1'b0;
    end
    if (a_win)      return 2'd2;
    else if (p_win) return 2'd1;
    else if (full)  return 2'd3;
    else            return 2'd0;
  endfunction

  state_t             state_q, state_d;
  logic [17:0]        b_q, b_d;
  logic [3:0]         i_q, i_d;
  logic [3:0]         j_q, j_d;
  logic signed [2:0]  best_q, best_d;
  logic signed [2:0]  min_q, min_d;
  logic [3:0]         best_i_q, best_i_d;
  logic [3:0]         move_q, move_d;
  logic               found_q, found_d;

  logic [17:0]        t_board;
  logic [17:0]        u_board;
  logic [1:0]         eval_b, eval_t, eval_u;
  logic signed [2:0]  reply_val;
  logic signed [2:0]  min_next;
  logic signed [2:0]  score;
  logic               score_valid;
  logic               step_i;
  logic               take;

  always_comb begin
    t_board   = set_cell(b_q, i_q, CELL_AI);
    u_board   = set_cell(t_board, j_q, CELL_PLAYER);
    eval_b    = eval_board(b_q);
    eval_t    = eval_board(t_board);
    eval_u    = eval_board(u_board);
    reply_val = (cell_of(t_board, j_q) == CELL_EMPTY && eval_u == 2'd1) ? -3'sd1 : 3'sd0;
    min_next  = (reply_val < min_q) ? reply_val : min_q;
  end

  always_comb begin
    state_d     = state_q;
    b_d         = b_q;
    i_d         = i_q;
    j_d         = j_q;
    best_d      = best_q;
    min_d       = min_q;
    best_i_d    = best_i_q;
    move_d      = move_q;
    found_d     = found_q;
    score       = 3'sd0;
    score_valid = 1'b0;
    step_i      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          b_d     = board;
          i_d     = 4'd0;
          best_d  = -3'sd2;
          state_d = S_CHK;
        end
      end
      S_CHK: begin
        if (eval_b != 2'd0) begin
          found_d = 1'b0;
          move_d  = 4'hF;
          state_d = S_FIN;
        end else begin
          state_d = S_CAND;
        end
      end
      S_CAND: begin
        if (cell_of(b_q, i_q) != CELL_EMPTY) begin
          step_i = 1'b1;
        end else if (eval_t == 2'd2) begin
          score       = 3'sd1;
          score_valid = 1'b1;
          step_i      = 1'b1;
        end else if (eval_t == 2'd3) begin
          score_valid = 1'b1;
          step_i      = 1'b1;
        end else begin
          min_d   = 3'sd1;
          j_d     = 4'd0;
          state_d = S_REPLY;
        end
      end
      S_REPLY: begin
        min_d = min_next;
        if (j_q == 4'd8) begin
          score       = min_next;
          score_valid = 1'b1;
          step_i      = 1'b1;
        end else begin
          j_d = j_q + 4'd1;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Strict greater-than keeps the lowest index on ties.
    take = score_valid && (score > best_q);
    if (take) begin
      best_d   = score;
      best_i_d = i_q;
    end

    // The last candidate exits straight to FIN so no extra CAND cycle is spent.
    if (step_i) begin
      if (i_q == 4'd8) begin
        found_d = 1'b1;
        move_d  = take ? i_q : best_i_q;
        state_d = S_FIN;
      end else begin
        i_d     = i_q + 4'd1;
        state_d = S_CAND;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      b_q      <= '0;
      i_q      <= '0;
      j_q      <= '0;
      best_q   <= -3'sd2;
      min_q    <= 3'sd1;
      best_i_q <= '0;
      move_q   <= 4'hF;
      found_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      b_q      <= b_d;
      i_q      <= i_d;
      j_q      <= j_d;
      best_q   <= best_d;
      min_q    <= min_d;
      best_i_q <= best_i_d;
      move_q   <= move_d;
      found_q  <= found_d;
    end
  end

  assign busy  = (state_q != S_IDLE);
  assign done  = (state_q == S_FIN);
  assign found = found_q;
  assign move  = move_q;

endmodule
